// File: rtl/wb_pipe_stage_pkg.sv
// Shared types and payload layout for the MEM->WB stage register.
// Scalar fields sit in the low bits; XLEN-wide fields are stacked above them.
package wb_pipe_stage_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_st_e;

  localparam int unsigned OFF_WB_SEL  = 0;
  localparam int unsigned OFF_MEM_VAL = 2;
  localparam int unsigned OFF_MEM_RW  = 4;
  localparam int unsigned OFF_RF_WEN  = 5;
  localparam int unsigned OFF_XBASE   = 6;

  localparam int unsigned FLD_INSTR = 0;
  localparam int unsigned FLD_PC    = 1;
  localparam int unsigned FLD_M4    = 2;
  localparam int unsigned FLD_ALU   = 3;

  function automatic int unsigned payload_w(input int unsigned xlen);
    return 4 * xlen + OFF_XBASE;
  endfunction

  function automatic int unsigned xfield_off(input int unsigned xlen, input int unsigned fld);
    return OFF_XBASE + fld * xlen;
  endfunction

endpackage

// File: rtl/wb_pipe_stage_skid_buf.sv
// Generic payload stage: one main entry plus an optional skid entry, valid/ready
// handshake on both sides and a synchronous flush that beats any push.
module wb_pipe_stage_skid_buf
  import wb_pipe_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_st_e        state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_s;
  logic             push_s;
  logic             pop_s;

  // With a skid entry, in_ready depends only on held state, never on out_ready.
  always_comb begin
    if (SKID) begin
      in_ready_s = (state_q != ST_TWO);
    end else begin
      in_ready_s = (state_q == ST_EMPTY) || out_ready;
    end
  end

  assign push_s = in_valid && in_ready_s;
  assign pop_s  = (state_q != ST_EMPTY) && out_ready;

  // Next-state and entry-load decisions; main always holds the oldest entry.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end else if (push_s) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Stage registers; reset drops every held entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= {WIDTH{1'b0}};
      skid_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, optional skid entry and flush.
// Side-effecting fields are forced to a bubble whenever the head is not valid.
module wb_pipe_stage
  import wb_pipe_stage_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter bit              SKID      = 1'b1,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] m4_out,
  input  logic            rf_wen,
  input  logic            mem_rw,
  input  logic [1:0]      mem_val,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instruction,
  input  logic [1:0]      wb_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out2,
  output logic [XLEN-1:0] wdata,
  output logic            rf_wen2,
  output logic            mem_rw2,
  output logic [1:0]      mem_val2,
  output logic [XLEN-1:0] pc2,
  output logic [XLEN-1:0] instruction2,
  output logic [1:0]      wb_sel2,
  output logic [4:0]      wb_addr,
  output logic [1:0]      occupancy
);

  localparam int unsigned PW        = payload_w(XLEN);
  localparam int unsigned OFF_INSTR = xfield_off(XLEN, FLD_INSTR);
  localparam int unsigned OFF_PC    = xfield_off(XLEN, FLD_PC);
  localparam int unsigned OFF_M4    = xfield_off(XLEN, FLD_M4);
  localparam int unsigned OFF_ALU   = xfield_off(XLEN, FLD_ALU);

  logic [PW-1:0] in_payload_s;
  logic [PW-1:0] head_s;
  logic          head_valid_s;

  assign in_payload_s[OFF_WB_SEL +: 2]   = wb_sel;
  assign in_payload_s[OFF_MEM_VAL +: 2]  = mem_val;
  assign in_payload_s[OFF_MEM_RW]        = mem_rw;
  assign in_payload_s[OFF_RF_WEN]        = rf_wen;
  assign in_payload_s[OFF_INSTR +: XLEN] = instruction;
  assign in_payload_s[OFF_PC +: XLEN]    = pc;
  assign in_payload_s[OFF_M4 +: XLEN]    = m4_out;
  assign in_payload_s[OFF_ALU +: XLEN]   = alu_out;

  wb_pipe_stage_skid_buf #(
    .WIDTH (PW),
    .SKID  (SKID)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload_s),
    .out_valid (head_valid_s),
    .out_ready (out_ready),
    .out_data  (head_s),
    .occupancy (occupancy)
  );

  // Unpack the head; a bubble must never carry a write, a memory access or a live opcode.
  always_comb begin
    alu_out2 = head_s[OFF_ALU +: XLEN];
    wdata    = head_s[OFF_M4 +: XLEN];
    pc2      = head_s[OFF_PC +: XLEN];
    wb_sel2  = head_s[OFF_WB_SEL +: 2];
    if (head_valid_s) begin
      rf_wen2      = head_s[OFF_RF_WEN];
      mem_rw2      = head_s[OFF_MEM_RW];
      mem_val2     = head_s[OFF_MEM_VAL +: 2];
      instruction2 = head_s[OFF_INSTR +: XLEN];
    end else begin
      rf_wen2      = 1'b0;
      mem_rw2      = 1'b0;
      mem_val2     = 2'b00;
      instruction2 = NOP_INSTR;
    end
  end

  assign out_valid = head_valid_s;
  assign wb_addr   = instruction2[11:7];

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Randomised bench for wb_pipe_stage: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_pipe_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] m4;
    logic        rf_wen;
    logic        mem_rw;
    logic [1:0]  mem_val;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  wb_sel;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] alu_out, m4_out, pc, instruction;
  logic        rf_wen, mem_rw;
  logic [1:0]  mem_val, wb_sel;
  logic [31:0] alu_out2, wdata, pc2, instruction2;
  logic        rf_wen2, mem_rw2;
  logic [1:0]  mem_val2, wb_sel2, occupancy;
  logic [4:0]  wb_addr;

  int   tests = 0;
  int   failed = 0;
  ent_t q[$];
  ent_t last_head = '0;
  ent_t e;

  always #5 clk = ~clk;

  wb_pipe_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .alu_out(alu_out), .m4_out(m4_out), .rf_wen(rf_wen), .mem_rw(mem_rw),
    .mem_val(mem_val), .pc(pc), .instruction(instruction), .wb_sel(wb_sel),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out2(alu_out2), .wdata(wdata),
    .rf_wen2(rf_wen2), .mem_rw2(mem_rw2), .mem_val2(mem_val2), .pc2(pc2),
    .instruction2(instruction2), .wb_sel2(wb_sel2), .wb_addr(wb_addr), .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ent_t d, input logic v);
    in_valid    = v;
    alu_out     = d.alu;
    m4_out      = d.m4;
    rf_wen      = d.rf_wen;
    mem_rw      = d.mem_rw;
    mem_val     = d.mem_val;
    pc          = d.pc;
    instruction = d.instr;
    wb_sel      = d.wb_sel;
  endtask

  function automatic ent_t rnd(input logic [31:0] p);
    ent_t r;
    r.alu     = $urandom;
    r.m4      = $urandom;
    r.rf_wen  = 1'($urandom_range(0, 1));
    r.mem_rw  = 1'($urandom_range(0, 1));
    r.mem_val = 2'($urandom_range(0, 3));
    r.pc      = p;
    r.instr   = $urandom;
    r.wb_sel  = 2'($urandom_range(0, 3));
    return r;
  endfunction

  function automatic ent_t cur_in();
    return '{alu: alu_out, m4: m4_out, rf_wen: rf_wen, mem_rw: mem_rw, mem_val: mem_val,
             pc: pc, instr: instruction, wb_sel: wb_sel};
  endfunction

  function automatic ent_t shown();
    if (q.size() != 0) return q[0];
    else return last_head;
  endfunction

  function automatic logic [31:0] exp_instr();
    if (q.size() != 0) return q[0].instr;
    else return NOP;
  endfunction

  function automatic logic [4:0] exp_rd();
    logic [31:0] t;
    t = exp_instr();
    return t[11:7];
  endfunction

  // Reference: a FIFO of at most two entries; flush empties it and eats any same-cycle push.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      last_head <= '0;
    end else begin
      if (flush) begin
        q.delete();
      end else if (in_valid && q.size() < 2) begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        q.push_back(cur_in());
      end else if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
      end
      if (q.size() != 0) last_head <= q[0];
    end
  end

  // Every cycle, compare all outputs against the model on the falling edge.
  always @(negedge clk) begin
    chk("out_valid", out_valid, q.size() != 0);
    chk("occupancy", occupancy, q.size());
    chk("in_ready", in_ready, q.size() < 2);
    chk("alu_out2", alu_out2, shown().alu);
    chk("wdata", wdata, shown().m4);
    chk("pc2", pc2, shown().pc);
    chk("wb_sel2", wb_sel2, shown().wb_sel);
    chk("rf_wen2", rf_wen2, (q.size() != 0) && shown().rf_wen);
    chk("mem_rw2", mem_rw2, (q.size() != 0) && shown().mem_rw);
    chk("mem_val2", mem_val2, (q.size() != 0) ? shown().mem_val : 2'b00);
    chk("instruction2", instruction2, exp_instr());
    chk("wb_addr", wb_addr, exp_rd());
  end

  initial begin
    flush     = 1'b0;
    out_ready = 1'b0;
    drive('0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_instruction2", instruction2, 32'h0000_0013);
    chk("rst_wb_addr", wb_addr, 5'd0);
    chk("rst_pc2", pc2, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single entry latency and rd extraction.
    e = rnd(32'h100);
    e.instr = 32'h00A0_0093;
    drive(e, 1'b1);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_wb_addr", wb_addr, 5'd1);
    chk("t1_pc2", pc2, 32'h100);
    step();
    chk("t1_drained", out_valid, 1'b0);

    // Back-pressure: only two of three pushes land, then drain in order.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = rnd(32'h200 + 32'(k));
      drive(e, 1'b1);
      step();
      if (k == 1) begin
        chk("t2_in_ready_full", in_ready, 1'b0);
        chk("t2_occ_full", occupancy, 2'd2);
      end
    end
    chk("t2_occ_still2", occupancy, 2'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t2_first", pc2, 32'h200);
    step();
    chk("t2_second", pc2, 32'h201);
    chk("t2_second_valid", out_valid, 1'b1);
    step();
    chk("t2_empty", out_valid, 1'b0);

    // Streaming at full rate.
    for (int i = 0; i < 100; i++) begin
      drive(rnd(32'h1000 + 32'(4 * i)), 1'b1);
      step();
      chk("t3_valid", out_valid, 1'b1);
      chk("t3_order", pc2, 32'h1000 + 32'(4 * i));
    end
    in_valid = 1'b0;
    step();
    chk("t3_end", out_valid, 1'b0);

    // Flush at occupancy two with a concurrent push.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = rnd(32'h300 + 32'(k));
      e.rf_wen = 1'b1;
      drive(e, 1'b1);
      step();
    end
    chk("t4_occ", occupancy, 2'd2);
    e = rnd(32'h380);
    e.rf_wen = 1'b1;
    drive(e, 1'b1);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_out_valid", out_valid, 1'b0);
    chk("t4_occ0", occupancy, 2'd0);
    chk("t4_rf_wen2", rf_wen2, 1'b0);
    chk("t4_instr2", instruction2, 32'h0000_0013);
    step();
    chk("t4_no_ghost", out_valid, 1'b0);

    // No side effect may follow a popped store/write into the bubble.
    out_ready = 1'b1;
    e = rnd(32'h400);
    e.rf_wen  = 1'b1;
    e.mem_rw  = 1'b1;
    e.mem_val = 2'b11;
    drive(e, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t5_rf_wen2_live", rf_wen2, 1'b1);
    chk("t5_mem_rw2_live", mem_rw2, 1'b1);
    step();
    chk("t5_bubble_valid", out_valid, 1'b0);
    chk("t5_bubble_rf_wen2", rf_wen2, 1'b0);
    chk("t5_bubble_mem_rw2", mem_rw2, 1'b0);
    chk("t5_bubble_mem_val2", mem_val2, 2'b00);

    // Random traffic with occasional flush, checked by the model.
    for (int i = 0; i < 400; i++) begin
      drive(rnd($urandom), 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 3) != 0 ? 1 : 0);
      flush     = 1'($urandom_range(0, 15) == 0 ? 1 : 0);
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset while full.
    out_ready = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      drive(rnd(32'h600 + 32'(k)), 1'b1);
      step();
    end
    in_valid = 1'b0;
    chk("t6_occ", occupancy, 2'd2);
    #2 reset = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_occ0", occupancy, 2'd0);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_instr2", instruction2, 32'h0000_0013);
    chk("t6_alu_out2", alu_out2, 32'h0);
    chk("t6_wb_addr", wb_addr, 5'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("t6_in_ready_rel", in_ready, 1'b1);
    drive(rnd(32'h500), 1'b1);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t6_restart_valid", out_valid, 1'b1);
    chk("t6_restart_pc2", pc2, 32'h500);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
